// File: rtl/onfi_status_poller.sv
// -----------------------------------------------------------------------------
// onfi_status_poller
//
// Sits directly upstream of the status-read engine (get_status). Repeatedly
// requests a Read Status (70h) byte over a req/ack handshake, evaluates the
// RDY bit, inserts a programmable gap between polls and reports the final
// status, fail bit, poll count, timeout and abort outcome to the command layer.
// Used after program, erase and reset operations to wait for an idle LUN.
//
// Build option:
//   POLL_ARDY_EN - when defined, "ready" also requires ARDY (status bit 5), so
//                  cache operations wait for the array to go idle as well.
//                  When undefined, only status[RDY_BIT] is evaluated.
// -----------------------------------------------------------------------------
module onfi_status_poller #(
  parameter int unsigned POLL_INTERVAL = 16,   // cycles from accepting ack to next req rise, >= 1
  parameter int unsigned TIMEOUT_POLLS = 1024, // max polls per operation, 1..65535
  parameter int unsigned RDY_BIT       = 6,    // status bit meaning LUN ready
  parameter int unsigned FAIL_BIT      = 0     // status bit meaning operation failed
) (
  input  logic        onfi_clk,
  input  logic        onfi_rst_n,
  // command-layer side
  input  logic        poll_start,
  input  logic        poll_abort,
  output logic        poll_busy,
  output logic        poll_done,
  output logic [7:0]  poll_status,
  output logic        poll_fail,
  output logic        poll_timeout,
  output logic        poll_aborted,
  output logic [15:0] poll_count,
  // status-reader side
  output logic        st_req,
  input  logic        st_ack,
  input  logic [7:0]  st_data
);

  // Gap counter is wide enough to hold POLL_INTERVAL-1 for any legal interval.
  localparam int unsigned     GAP_W     = $clog2(POLL_INTERVAL) + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_INTERVAL - 1);
  localparam logic [15:0]     COUNT_MAX = 16'(TIMEOUT_POLLS);
  localparam logic [2:0]      RDY_IDX   = 3'(RDY_BIT);
  localparam logic [2:0]      FAIL_IDX  = 3'(FAIL_BIT);
  localparam logic [2:0]      ARDY_IDX  = 3'd5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [GAP_W-1:0] gap_cnt;
  logic             abort_pending;

  logic             byte_ready;
  logic             abort_hit;
  logic [15:0]      count_next;
  logic             count_at_limit;

  // Decode the incoming status byte and the poll-count bookkeeping.
  always_comb begin
    // NOTE: every signal gets a value before any conditional logic so no
    // path leaves it unassigned; otherwise a latch would be inferred.
    byte_ready     = st_data[RDY_IDX];
    abort_hit      = abort_pending | poll_abort;
    count_next     = poll_count;
    count_at_limit = 1'b0;
`ifdef POLL_ARDY_EN
    byte_ready     = st_data[RDY_IDX] & st_data[ARDY_IDX];
`endif
    // Saturating increment: the count can never pass TIMEOUT_POLLS.
    if (poll_count != COUNT_MAX) begin
      count_next = poll_count + 16'd1;
    end
    count_at_limit = (count_next == COUNT_MAX);
  end

  // Poll sequencer: FSM, gap timer and all registered outputs.
  always_ff @(posedge onfi_clk or negedge onfi_rst_n) begin
    // NOTE: result registers are reset as well as the FSM, so every output
    // reads 0 the instant reset asserts, even mid-operation.
    if (!onfi_rst_n) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      abort_pending <= 1'b0;
      poll_busy     <= 1'b0;
      poll_done     <= 1'b0;
      poll_status   <= 8'h00;
      poll_fail     <= 1'b0;
      poll_timeout  <= 1'b0;
      poll_aborted  <= 1'b0;
      poll_count    <= 16'd0;
      st_req        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values and ordering inside the block does not matter.
      case (state)
        IDLE: begin
          abort_pending <= 1'b0;
          if (poll_start) begin
            state        <= REQ;
            st_req       <= 1'b1;
            poll_busy    <= 1'b1;
            poll_count   <= 16'd0;
            poll_timeout <= 1'b0;
            poll_fail    <= 1'b0;
            poll_aborted <= 1'b0;
          end
        end

        REQ: begin
          if (st_ack) begin
            // Handshake completes: capture the byte and decide what is next.
            st_req      <= 1'b0;
            poll_status <= st_data;
            poll_count  <= count_next;
            if (byte_ready) begin
              // Ready wins over both abort and timeout on the same byte.
              state     <= DONE;
              poll_done <= 1'b1;
              poll_fail <= st_data[FAIL_IDX];
            end else if (abort_hit) begin
              state        <= DONE;
              poll_done    <= 1'b1;
              poll_aborted <= 1'b1;
            end else if (count_at_limit) begin
              state        <= DONE;
              poll_done    <= 1'b1;
              poll_timeout <= 1'b1;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else if (poll_abort) begin
            // Never break an outstanding handshake; act on it at the ack.
            abort_pending <= 1'b1;
          end
        end

        GAP: begin
          if (poll_abort) begin
            state        <= DONE;
            poll_done    <= 1'b1;
            poll_aborted <= 1'b1;
          end else if (gap_cnt == '0) begin
            state  <= REQ;
            st_req <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        DONE: begin
          // One-cycle completion pulse; results hold until the next start.
          state         <= IDLE;
          poll_done     <= 1'b0;
          poll_busy     <= 1'b0;
          abort_pending <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
